sparrow_fetch: RTL and testbench
================================

# sparrow_fetch

Instruction fetch stage for the sparrow RV32I core. It holds the program counter and issues one instruction-memory request at a time over a req/gnt/rvalid handshake. It presents each fetched instruction to decode through a one-entry output register. It also consumes the resolved branch decision from `sparrow_branch_control` (taken flag plus target address from execute): on a taken branch it redirects the PC, discards any wrong-path response still in flight, and flushes the output register.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC value loaded on reset. Bits [1:0] must be 0.
- `i_clk` input 1: clock; all state updates on the rising edge.
- `i_rst_n` input 1: asynchronous, active-low reset.
- `i_branch_taken` input 1: taken-branch pulse from branch control (execute stage).
- `i_branch_target` input 32: redirect address, valid when `i_branch_taken`=1.
- `i_stall` input 1: decode cannot accept; the output register holds.
- `o_imem_req` output 1: fetch request.
- `o_imem_addr` output 32: fetch address; always the current PC, bits [1:0]=0.
- `i_imem_gnt` input 1: request accepted this cycle.
- `i_imem_rvalid` input 1: response data valid. Arrives ≥1 cycle after its grant, in order, at most one outstanding.
- `i_imem_rdata` input 32: instruction word.
- `o_instr_valid` output 1: the output register holds an instruction.
- `o_instr` output 32: fetched instruction.
- `o_instr_pc` output 32: address of `o_instr`.

## Operation
- State machine:
  - IDLE: the state held during reset. Unconditionally moves to REQ on the first clock after reset deasserts.
  - REQ: `o_imem_req` = (!`o_instr_valid` || !`i_stall`). Request is only issued when the output slot is empty or is being consumed this cycle. On req && gnt, move to WAIT.
  - WAIT: no request. On `i_imem_rvalid`, move to REQ.
- PC update:
  - On req && gnt without redirect: pc ← pc + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
- Redirect (`i_branch_taken`=1). Redirect has priority over every other PC update.
  - pc ← {`i_branch_target`[31:2], 2'b00}.
  - `o_instr_valid` ← 0.
  - If in WAIT, or moving REQ→WAIT this cycle (gnt at the old PC): set the `discard` flag.
- Discard:
  - The next `i_imem_rvalid` while `discard`=1 is dropped (output register untouched) and clears `discard`.
  - Redirect in the same cycle as rvalid: that response is dropped, with or without `discard`.
  - Redirect in REQ without gnt: address changes to the target next cycle. The memory must tolerate an un-granted request changing address.
- Output register:
  - On rvalid (not dropped): `o_instr` ← rdata, `o_instr_pc` ← address of that request, `o_instr_valid` ← 1.
  - Otherwise, if `i_stall`=0: `o_instr_valid` ← 0.
  - While `i_stall`=1 the valid, instruction and PC fields hold.
- Back-to-back redirects: the last one wins. `discard` stays set until exactly one response has been dropped.

## Timing
- Reset values:
  - state=IDLE, pc=`RESET_PC`, `discard`=0.
  - `o_imem_req`=0, `o_imem_addr`=`RESET_PC`.
  - `o_instr_valid`=0, `o_instr`=0, `o_instr_pc`=0.
- Reset asserted mid-transaction clears everything asynchronously. The outstanding response is not tracked: the memory must also be reset.
- Zero-wait memory (gnt with req, rvalid next cycle):
  - Request in cycle N, rvalid in N+1, `o_instr_valid` in N+2.
  - Sustained throughput is one instruction per 2 cycles.
- Redirect in cycle N:
  - `o_imem_req`=1 with `o_imem_addr`=target in N+1 if in REQ.
  - Otherwise in the cycle after the discarded response arrives.
- `o_imem_addr` and `o_imem_req` are derived from registered state only (no combinational path from imem inputs).

## Test plan
- Reset with `RESET_PC`=0x100, zero-wait memory returning addr^0xA5A5_0000 → `o_instr_valid` first rises 3 cycles after reset release with `o_instr_pc`=0x100. Subsequent PCs are 0x104, 0x108, one every 2 cycles.
- `i_stall` held high for 5 cycles with `o_instr_valid`=1 → no `o_imem_req`. `o_instr`/`o_instr_pc` stable. Fetching resumes the cycle `i_stall` drops.
- `i_branch_taken` with target 0x2003 while in WAIT, rvalid 3 cycles later → that response is dropped. Next request is at 0x2000. `o_instr_valid`=0 until 0x2000 returns.
- `i_branch_taken` in the same cycle as `i_imem_rvalid` → response dropped, `o_instr_valid`=0 next cycle, next request at the target.
- Redirect in REQ with gnt held low → `o_imem_addr` switches to the target next cycle, and no response is discarded when it is granted.
- `RESET_PC`=0xFFFF_FFFC → second request address is 0x0000_0000.

Source files
------------

// File: rtl/sparrow_fetch.sv
// sparrow_fetch -- instruction fetch stage of the sparrow RV32I core.
//
// Holds the program counter, issues one instruction-memory request at a time
// over a req/gnt/rvalid handshake and presents each fetched word to decode
// through a one-entry output register. A taken branch from execute redirects
// the PC, drops any wrong-path response still in flight and flushes the
// output register.
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_branch_taken            taken-branch pulse from branch control
//   i_branch_target[31:0]     redirect address (bits [1:0] ignored)
//   i_stall                   decode cannot accept; output register holds
//   o_imem_req                fetch request
//   o_imem_addr[31:0]         fetch address (current PC, word aligned)
//   i_imem_gnt                request accepted this cycle
//   i_imem_rvalid             response valid (in order, one outstanding)
//   i_imem_rdata[31:0]        instruction word
//   o_instr_valid             output register holds an instruction
//   o_instr[31:0]             fetched instruction
//   o_instr_pc[31:0]          address of o_instr
module sparrow_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    input  logic        i_stall,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_instr_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;     // address of the outstanding request
    logic        discard_q, discard_d;   // next response is wrong-path
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;

    logic        req;
    logic        fire;
    logic        rsp;
    logic        unused_target_bits;

    assign unused_target_bits = ^i_branch_target[1:0];

    // Only request when the output slot is free or drains this cycle.
    assign req  = (state_q == ST_REQ) && (!valid_q || !i_stall);
    assign fire = req && i_imem_gnt;
    // Responses are only meaningful while one is outstanding.
    assign rsp  = i_imem_rvalid && (state_q == ST_WAIT);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        discard_d  = discard_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;

        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ:  if (fire) state_d = ST_WAIT;
            ST_WAIT: if (rsp) state_d = ST_REQ;
            default: state_d = ST_IDLE;
        endcase

        if (fire) begin
            pc_d     = pc_q + 32'd4;
            req_pc_d = pc_q;
        end

        // Any arriving response consumes a pending discard; a redirect
        // re-arms it only if a response will still be in flight afterwards
        // (an rvalid in the redirect cycle is dropped directly instead).
        if (rsp) begin
            discard_d = 1'b0;
        end
        if (i_branch_taken) begin
            pc_d = {i_branch_target[31:2], 2'b00};
            if (fire || ((state_q == ST_WAIT) && !rsp)) begin
                discard_d = 1'b1;
            end
        end

        if (i_branch_taken) begin
            valid_d = 1'b0;
        end else if (rsp && !discard_q) begin
            valid_d    = 1'b1;
            instr_d    = i_imem_rdata;
            instr_pc_d = req_pc_q;
        end else if (!i_stall) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= {RESET_PC[31:2], 2'b00};
            req_pc_q   <= '0;
            discard_q  <= 1'b0;
            valid_q    <= 1'b0;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            discard_q  <= discard_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    assign o_imem_req    = req;
    assign o_imem_addr   = pc_q;
    assign o_instr_valid = valid_q;
    assign o_instr       = instr_q;
    assign o_instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_sparrow_fetch.sv
// Self-checking bench for sparrow_fetch: a memory model with random grant and
// latency, directed redirect/stall scenarios, and a scoreboard of expected
// program-order (pc, instr) pairs popped whenever decode consumes a word.
module tb_sparrow_fetch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        br;
    logic [31:0] br_tgt;
    logic        stall;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic        ivalid;
    logic [31:0] instr;
    logic [31:0] ipc;

    sparrow_fetch #(.RESET_PC(32'h0000_0100)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_branch_taken(br), .i_branch_target(br_tgt), .i_stall(stall),
        .o_imem_req(req), .o_imem_addr(addr), .i_imem_gnt(gnt),
        .i_imem_rvalid(rvalid), .i_imem_rdata(rdata),
        .o_instr_valid(ivalid), .o_instr(instr), .o_instr_pc(ipc)
    );

    // Second instance exercising PC wrap-around.
    logic        br2 = 1'b0;
    logic [31:0] tgt2 = '0;
    logic        stall2 = 1'b0;
    logic        gnt2 = 1'b1;
    logic        rv2;
    logic [31:0] rdata2 = '0;
    logic        req2;
    logic [31:0] addr2;
    logic        v2;
    logic [31:0] instr2;
    logic [31:0] ipc2;

    sparrow_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_branch_taken(br2), .i_branch_target(tgt2), .i_stall(stall2),
        .o_imem_req(req2), .o_imem_addr(addr2), .i_imem_gnt(gnt2),
        .i_imem_rvalid(rv2), .i_imem_rdata(rdata2),
        .o_instr_valid(v2), .o_instr(instr2), .o_instr_pc(ipc2)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;
    exp_t        exp_q[$];
    logic [31:0] next_exp;

    // stimulus knobs
    int          gnt_pct, stall_pct, br_pct, lat_min, lat_max;
    bit          stall_on_valid;
    bit          f_br;
    logic [31:0] f_tgt;

    // memory model / bookkeeping
    bit          outst;
    int          cnt;
    logic [31:0] out_addr;
    bit          br_pending;
    logic [31:0] br_pend_tgt;
    bit          granted_now;
    bit          req2_seen;
    int          consumed = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic refill();
        exp_t e;
        while (exp_q.size() < 8) begin
            e.pc   = next_exp;
            e.word = mem_word(next_exp);
            exp_q.push_back(e);
            next_exp = next_exp + 32'd4;
        end
    endtask

    // One clock cycle: apply a pending redirect to the model at the edge it
    // takes effect, drive inputs #1 after the edge, then observe the request.
    task automatic step();
        @(posedge clk);
        if (br_pending) begin
            exp_q.delete();
            next_exp   = {br_pend_tgt[31:2], 2'b00};
            br_pending = 1'b0;
        end
        refill();
        #1;
        rvalid = 1'b0;
        rdata  = '0;
        if (outst) begin
            if (cnt <= 1) begin
                rvalid = 1'b1;
                rdata  = mem_word(out_addr);
                outst  = 1'b0;
            end else begin
                cnt--;
            end
        end
        rv2 = req2_seen;
        if (stall_on_valid) stall = ivalid;
        else stall = ($urandom_range(99, 0) < stall_pct);
        gnt    = ($urandom_range(99, 0) < gnt_pct);
        br     = f_br || ($urandom_range(99, 0) < br_pct);
        br_tgt = f_br ? f_tgt : $urandom;
        f_br   = 1'b0;
        #1;
        granted_now = req && gnt;
        req2_seen   = req2;
        if (req) chk("addr_align", {30'b0, addr[1:0]}, 32'd0);
        if (req && gnt) begin
            if (outst) begin
                checks++;
                errors++;
                $display("FAIL one_outstanding actual=second_grant required=none");
            end
            outst    = 1'b1;
            out_addr = addr;
            cnt      = $urandom_range(lat_max, lat_min);
        end
        if (br) begin
            br_pending  = 1'b1;
            br_pend_tgt = br_tgt;
        end
    endtask

    // Scoreboard monitor: a word is consumed when valid and not stalled.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && ivalid === 1'b1 && stall === 1'b0) begin
            consumed++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty actual=pc %h required=expected_entry", ipc);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", ipc, e.pc);
                chk("sb_instr", instr, e.word);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] hold_i, hold_pc;
        logic [31:0] a2[$];
        int          c0;
        bit          got;

        rst_n = 1'b0; br = 1'b0; br_tgt = '0; stall = 1'b0;
        gnt = 1'b0; rvalid = 1'b0; rdata = '0; rv2 = 1'b0;
        gnt_pct = 100; stall_pct = 0; br_pct = 0; lat_min = 1; lat_max = 1;
        stall_on_valid = 1'b0; f_br = 1'b0; f_tgt = '0;
        outst = 1'b0; cnt = 0; out_addr = '0; br_pending = 1'b0;
        br_pend_tgt = '0; granted_now = 1'b0; req2_seen = 1'b0;
        next_exp = 32'h0000_0100;
        exp_q.delete();
        refill();

        repeat (3) step();
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_addr", addr, 32'h0000_0100);
        chk("rst_valid", 32'(ivalid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", ipc, 32'd0);
        chk("rst_addr_wrap", addr2, 32'hFFFF_FFFC);
        rst_n = 1'b1;

        // Zero-wait memory: first valid three edges after release.
        for (int k = 1; k <= 3; k++) begin
            step();
            if (req2) a2.push_back(addr2);
            if (k < 3) chk("first_valid_early", 32'(ivalid), 32'd0);
        end
        chk("first_valid", 32'(ivalid), 32'd1);
        chk("first_pc", ipc, 32'h0000_0100);
        if (a2.size() >= 2) begin
            chk("wrap_req0", a2[0], 32'hFFFF_FFFC);
            chk("wrap_req1", a2[1], 32'h0000_0000);
        end else begin
            checks++;
            errors++;
            $display("FAIL wrap_reqs actual=%0d required=2", a2.size());
        end

        c0 = consumed;
        repeat (8) step();
        chk("throughput", 32'(consumed - c0), 32'd4);

        // Stall for five cycles with a valid instruction held.
        stall_on_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (ivalid) break;
        end
        chk("stall_setup_valid", 32'(ivalid), 32'd1);
        hold_i  = instr;
        hold_pc = ipc;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) step();
            chk("stall_no_req", 32'(req), 32'd0);
            chk("stall_valid", 32'(ivalid), 32'd1);
            chk("stall_instr", instr, hold_i);
            chk("stall_pc", ipc, hold_pc);
        end
        stall_on_valid = 1'b0;
        stall_pct = 0;
        step();
        chk("resume_req", 32'(req), 32'd1);

        // Redirect while waiting on a slow response.
        lat_min = 3; lat_max = 3;
        for (int k = 0; k < 12; k++) begin
            step();
            if (granted_now) break;
        end
        chk("bw_grant_seen", 32'(granted_now), 32'd1);
        f_br = 1'b1; f_tgt = 32'h0000_2003;
        step();
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("bw_req", 32'(req), (k == 3) ? 32'd1 : 32'd0);
            chk("bw_valid_flushed", 32'(ivalid), 32'd0);
        end
        chk("bw_addr", addr, 32'h0000_2000);
        got = 1'b0;
        for (int k = 0; k < 12 && !got; k++) begin
            step();
            if (ivalid) got = 1'b1;
        end
        chk("bw_first_pc", ipc, 32'h0000_2000);

        // Redirect in the same cycle as the response.
        lat_min = 2; lat_max = 2;
        for (int k = 0; k < 12; k++) begin
            step();
            if (granted_now) break;
        end
        chk("bs_grant_seen", 32'(granted_now), 32'd1);
        step();
        f_br = 1'b1; f_tgt = 32'h0000_3000;
        step();
        step();
        chk("bs_valid", 32'(ivalid), 32'd0);
        chk("bs_req", 32'(req), 32'd1);
        chk("bs_addr", addr, 32'h0000_3000);
        got = 1'b0;
        for (int k = 0; k < 12 && !got; k++) begin
            step();
            if (ivalid) got = 1'b1;
        end
        chk("bs_first_pc", ipc, 32'h0000_3000);

        // Redirect in REQ with grant held low.
        lat_min = 1; lat_max = 1; gnt_pct = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (req) break;
        end
        chk("br_req_setup", 32'(req), 32'd1);
        f_br = 1'b1; f_tgt = 32'h0000_4008;
        step();
        step();
        chk("br_req", 32'(req), 32'd1);
        chk("br_addr", addr, 32'h0000_4008);
        gnt_pct = 100;
        got = 1'b0;
        for (int k = 0; k < 12 && !got; k++) begin
            step();
            if (ivalid) got = 1'b1;
        end
        chk("br_first_pc", ipc, 32'h0000_4008);

        // Random traffic against the scoreboard.
        gnt_pct = 70; stall_pct = 25; br_pct = 4; lat_min = 1; lat_max = 4;
        c0 = consumed;
        repeat (3000) step();
        chk("progress", 32'(consumed - c0 > 150), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
